// File: rtl/offnariscv_pkg.sv
// Shared types for the in-order commit stage: dispatch, FU writeback, RF write and queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package offnariscv_pkg;

  localparam int CU_XLEN   = 32;
  localparam int CU_NUM_FU = 2;

  localparam int FU_ALU = 0;
  localparam int FU_BRU = 1;

  // Op bookkeeping carried from dispatch to the register file
  typedef struct packed {
    logic [CU_XLEN-1:0] pc;
    logic [4:0]         rd;
  } ex_data_t;

  typedef struct packed {
    ex_data_t               ex_data;
    logic [CU_NUM_FU-1:0]   fu_sel;
  } exwb_tdata_t;

  typedef struct packed {
    logic [CU_XLEN-1:0] result;
    logic               taken;
    logic [CU_XLEN-1:0] new_pc;
  } fu_wb_tdata_t;

  typedef struct packed {
    ex_data_t               ex_data;
    logic [CU_NUM_FU-1:0]   fu_sel;
    logic                   epoch;
  } commit_entry_t;

  typedef struct packed {
    logic [CU_XLEN-1:0] wdata;
    ex_data_t           ex_data;
  } wbrf_tdata_t;

  // Tag a dispatched op with the epoch it was issued under
  function automatic commit_entry_t mk_entry(input exwb_tdata_t d, input logic ep);
    commit_entry_t e;
    e.ex_data = d.ex_data;
    e.fu_sel  = d.fu_sel;
    e.epoch   = ep;
    return e;
  endfunction

endpackage

// File: rtl/commit_unit_queue.sv
// Program-order commit queue: DEPTH-entry synchronous FIFO with occupancy count.
// Latency: an entry written in cycle t is visible at the head from t+1.
// Backpressure: caller must only push when !full and only pop when !empty.
module commit_queue
  import offnariscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  commit_entry_t          push_dat,
  input  logic                   pop,
  output commit_entry_t          head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  commit_entry_t    mem_q [DEPTH];
  commit_entry_t    mem_d [DEPTH];

  // Next pointers, count and storage; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every queued entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/commit_unit.sv
// In-order commit: queues dispatched ops, merges FU results at the head, writes RF, redirects PCG, squashes by epoch.
// Latency: head fires in the same cycle its FU result is valid; a pushed op reaches the head no earlier than next cycle.
// Backpressure: disp_tready = !full (registered only); head holds until wbrf (and wbpcg for redirects) accept. Optional COMMIT_INSTRET_EN adds instret.
module commit_unit
  import offnariscv_pkg::*;
#(
  parameter int NUM_FU = CU_NUM_FU,
  parameter int DEPTH  = 4,
  parameter int XLEN   = CU_XLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_tvalid,
  output logic               disp_tready,
  input  exwb_tdata_t        disp_tdata,
  input  logic [NUM_FU-1:0]  fu_tvalid,
  output logic [NUM_FU-1:0]  fu_tready,
  input  fu_wb_tdata_t       fu_tdata [NUM_FU],
  output logic               wbrf_tvalid,
  input  logic               wbrf_tready,
  output wbrf_tdata_t        wbrf_tdata,
  output logic               wbpcg_tvalid,
  input  logic               wbpcg_tready,
  output logic [XLEN-1:0]    wbpcg_tdata
`ifdef COMMIT_INSTRET_EN
  ,
  output logic [63:0]        instret
`endif
);

  logic                   push, pop, full, empty;
  logic [$clog2(DEPTH):0] count;
  commit_entry_t          head;
  logic                   epoch_q, epoch_d;

  logic                   sel_vld, sel_bru, fu_ok;
  fu_wb_tdata_t           sel_dat;
  logic                   head_live, redir, live_fire, stale_pop;

  assign disp_tready = !full;
  assign push        = disp_tvalid && !full;

  commit_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (mk_entry(disp_tdata, epoch_q)),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Pick the writeback channel named by the head's one-hot fu_sel
  always_comb begin
    sel_vld = 1'b0;
    sel_bru = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (head.fu_sel[i]) begin
        sel_vld = fu_tvalid[i];
        sel_dat = fu_tdata[i];
        sel_bru = (i == FU_BRU);
      end
    end
  end

  // Head fire/drain decision and output channel drive
  always_comb begin
    fu_ok        = (head.fu_sel == '0) || sel_vld;
    head_live    = !empty && (head.epoch == epoch_q);
    redir        = head_live && sel_bru && sel_dat.taken;
    wbrf_tvalid  = head_live && fu_ok && (!redir || wbpcg_tready);
    wbpcg_tvalid = redir && fu_ok && wbrf_tready;
    live_fire    = wbrf_tvalid && wbrf_tready;
    stale_pop    = !empty && !head_live && fu_ok;
    pop          = live_fire || stale_pop;
    fu_tready    = pop ? head.fu_sel : '0;
    wbrf_tdata.wdata   = sel_dat.result;
    wbrf_tdata.ex_data = head.ex_data;
    wbpcg_tdata  = sel_dat.new_pc;
    epoch_d      = epoch_q ^ (live_fire && redir);
  end

  // Epoch flips on each accepted redirect so younger queued ops become stale
  always_ff @(posedge clk) begin
    if (rst) epoch_q <= 1'b0;
    else     epoch_q <= epoch_d;
  end

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Count live retirements only; stale drains are not instructions
  always_comb begin
    instret_d = instret_q + (live_fire ? 64'd1 : 64'd0);
  end

  // Retired-op counter register, wraps at 2^64
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

  // Simulation-only sanity: one FU per op and queue occupancy in range
  always @(posedge clk) begin
    if (!rst && push) begin
      assert ($onehot0(disp_tdata.fu_sel))
        else $error("commit_unit: multi-hot fu_sel %b", disp_tdata.fu_sel);
    end
    if (!rst) begin
      assert (32'(count) <= DEPTH)
        else $error("commit_unit: queue count %0d out of range", count);
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: reset, ALU commit, no-FU ops, redirect squash, full queue,
// PCG stall, redirect-with-push, mid-run reset, and (with COMMIT_INSTRET_EN) instret.
module tb_commit_unit;
  import offnariscv_pkg::*;

  localparam int NUM_FU = 2;
  localparam int DEPTH  = 4;
  localparam int XLEN   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_tvalid;
  logic              disp_tready;
  exwb_tdata_t       disp_tdata;
  logic [NUM_FU-1:0] fu_tvalid;
  logic [NUM_FU-1:0] fu_tready;
  fu_wb_tdata_t      fu_tdata [NUM_FU];
  logic              wbrf_tvalid;
  logic              wbrf_tready;
  wbrf_tdata_t       wbrf_tdata;
  logic              wbpcg_tvalid;
  logic              wbpcg_tready;
  logic [XLEN-1:0]   wbpcg_tdata;
`ifdef COMMIT_INSTRET_EN
  logic [63:0]       instret;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  commit_unit #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .disp_tvalid  (disp_tvalid),
    .disp_tready  (disp_tready),
    .disp_tdata   (disp_tdata),
    .fu_tvalid    (fu_tvalid),
    .fu_tready    (fu_tready),
    .fu_tdata     (fu_tdata),
    .wbrf_tvalid  (wbrf_tvalid),
    .wbrf_tready  (wbrf_tready),
    .wbrf_tdata   (wbrf_tdata),
    .wbpcg_tvalid (wbpcg_tvalid),
    .wbpcg_tready (wbpcg_tready),
    .wbpcg_tdata  (wbpcg_tdata)
`ifdef COMMIT_INSTRET_EN
    ,
    .instret      (instret)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic v, input logic [1:0] sel, input logic [4:0] rd);
    disp_tvalid               = v;
    disp_tdata.fu_sel         = sel;
    disp_tdata.ex_data.rd     = rd;
    disp_tdata.ex_data.pc     = 32'h1000 + 32'(rd);
  endtask

  task automatic set_fu(input int k, input logic v, input logic [31:0] res,
                        input logic tk, input logic [31:0] npc);
    fu_tvalid[k]       = v;
    fu_tdata[k].result = res;
    fu_tdata[k].taken  = tk;
    fu_tdata[k].new_pc = npc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_disp(1'b0, 2'b00, 5'd0);
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_fu(1, 1'b0, 32'd0, 1'b0, 32'd0);
    wbrf_tready  = 1'b1;
    wbpcg_tready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (disp_tready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_rdy got %0b exp 1", disp_tready); end
    n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wbrf_vld got %0b exp 0", wbrf_tvalid); end
    n_tests++; if (wbpcg_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wbpcg_vld got %0b exp 0", wbpcg_tvalid); end
    n_tests++; if (fu_tready !== 2'b00) begin n_fail++; $display("FAIL reset_fu_rdy got %b exp 00", fu_tready); end
`ifdef COMMIT_INSTRET_EN
    n_tests++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d exp 0", instret); end
`endif
  endtask

  task automatic test_alu();
    set_disp(1'b1, 2'b01, 5'd5);
    set_fu(0, 1'b1, 32'h1234, 1'b0, 32'd0);
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL alu_push_cycle_vld got %0b exp 0", wbrf_tvalid); end
    n_tests++; if (fu_tready !== 2'b00) begin n_fail++; $display("FAIL alu_push_cycle_fu_rdy got %b exp 00", fu_tready); end
    tick();
    set_disp(1'b0, 2'b00, 5'd0);
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b1) begin n_fail++; $display("FAIL alu_wbrf_vld got %0b exp 1", wbrf_tvalid); end
    n_tests++; if (wbrf_tdata.wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata got %h exp 00001234", wbrf_tdata.wdata); end
    n_tests++; if (wbrf_tdata.ex_data.rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0d exp 5", wbrf_tdata.ex_data.rd); end
    n_tests++; if (wbpcg_tvalid !== 1'b0) begin n_fail++; $display("FAIL alu_wbpcg_vld got %0b exp 0", wbpcg_tvalid); end
    n_tests++; if (fu_tready !== 2'b01) begin n_fail++; $display("FAIL alu_fu_rdy got %b exp 01", fu_tready); end
    tick();
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL alu_after_pop_vld got %0b exp 0", wbrf_tvalid); end
  endtask

  task automatic test_no_fu();
    set_disp(1'b1, 2'b00, 5'd9);
    tick();
    set_disp(1'b0, 2'b00, 5'd0);
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b1) begin n_fail++; $display("FAIL nofu_vld got %0b exp 1", wbrf_tvalid); end
    n_tests++; if (wbrf_tdata.wdata !== 32'd0) begin n_fail++; $display("FAIL nofu_wdata got %h exp 0", wbrf_tdata.wdata); end
    n_tests++; if (fu_tready !== 2'b00) begin n_fail++; $display("FAIL nofu_fu_rdy got %b exp 00", fu_tready); end
    tick();
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL nofu_after_vld got %0b exp 0", wbrf_tvalid); end
  endtask

  task automatic test_redirect();
    set_disp(1'b1, 2'b10, 5'd1); tick();
    set_disp(1'b1, 2'b01, 5'd2); tick();
    set_disp(1'b1, 2'b01, 5'd3); tick();
    set_disp(1'b0, 2'b00, 5'd0);
    set_fu(1, 1'b1, 32'hdead, 1'b1, 32'h80);
    set_fu(0, 1'b1, 32'h11, 1'b0, 32'd0);
    #1;
    n_tests++; if (wbpcg_tvalid !== 1'b1) begin n_fail++; $display("FAIL redir_pcg_vld got %0b exp 1", wbpcg_tvalid); end
    n_tests++; if (wbpcg_tdata !== 32'h80) begin n_fail++; $display("FAIL redir_pcg_dat got %h exp 00000080", wbpcg_tdata); end
    n_tests++; if (wbrf_tvalid !== 1'b1) begin n_fail++; $display("FAIL redir_wbrf_vld got %0b exp 1", wbrf_tvalid); end
    n_tests++; if (wbrf_tdata.wdata !== 32'hdead) begin n_fail++; $display("FAIL redir_wdata got %h exp 0000dead", wbrf_tdata.wdata); end
    n_tests++; if (fu_tready !== 2'b10) begin n_fail++; $display("FAIL redir_fu_rdy got %b exp 10", fu_tready); end
    tick();
    set_fu(1, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      set_fu(0, 1'b1, 32'h11 + 32'(i), 1'b0, 32'd0);
      #1;
      n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL squash%0d_wbrf_vld got %0b exp 0", i, wbrf_tvalid); end
      n_tests++; if (wbpcg_tvalid !== 1'b0) begin n_fail++; $display("FAIL squash%0d_pcg_vld got %0b exp 0", i, wbpcg_tvalid); end
      n_tests++; if (fu_tready !== 2'b01) begin n_fail++; $display("FAIL squash%0d_fu_rdy got %b exp 01", i, fu_tready); end
      tick();
    end
    #1;
    n_tests++; if (fu_tready !== 2'b00) begin n_fail++; $display("FAIL squash_empty_fu_rdy got %b exp 00", fu_tready); end
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_disp(1'b1, 2'b01, 5'd4);
    tick();
    set_disp(1'b0, 2'b00, 5'd0);
    set_fu(0, 1'b1, 32'h33, 1'b0, 32'd0);
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b1) begin n_fail++; $display("FAIL post_redir_live_vld got %0b exp 1", wbrf_tvalid); end
    n_tests++; if (wbrf_tdata.wdata !== 32'h33) begin n_fail++; $display("FAIL post_redir_wdata got %h exp 00000033", wbrf_tdata.wdata); end
    tick();
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      set_disp(1'b1, 2'b01, 5'(i));
      #1;
      n_tests++; if (disp_tready !== 1'b1) begin n_fail++; $display("FAIL fill%0d_disp_rdy got %0b exp 1", i, disp_tready); end
      tick();
    end
    set_disp(1'b1, 2'b01, 5'd5);
    set_fu(0, 1'b1, 32'ha1, 1'b0, 32'd0);
    #1;
    n_tests++; if (disp_tready !== 1'b0) begin n_fail++; $display("FAIL full_disp_rdy got %0b exp 0", disp_tready); end
    n_tests++; if (fu_tready !== 2'b01) begin n_fail++; $display("FAIL full_pop_fu_rdy got %b exp 01", fu_tready); end
    n_tests++; if (wbrf_tdata.ex_data.rd !== 5'd1) begin n_fail++; $display("FAIL full_pop_rd got %0d exp 1", wbrf_tdata.ex_data.rd); end
    tick();
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    n_tests++; if (disp_tready !== 1'b1) begin n_fail++; $display("FAIL after_pop_disp_rdy got %0b exp 1", disp_tready); end
    tick();
    set_disp(1'b1, 2'b01, 5'd6);
    set_fu(0, 1'b1, 32'ha2, 1'b0, 32'd0);
    #1;
    n_tests++; if (disp_tready !== 1'b0) begin n_fail++; $display("FAIL refull_disp_rdy got %0b exp 0", disp_tready); end
    n_tests++; if (wbrf_tdata.ex_data.rd !== 5'd2) begin n_fail++; $display("FAIL refull_rd got %0d exp 2", wbrf_tdata.ex_data.rd); end
    tick();
    #1;
    n_tests++; if (disp_tready !== 1'b1) begin n_fail++; $display("FAIL pushpop_disp_rdy got %0b exp 1", disp_tready); end
    n_tests++; if (wbrf_tdata.ex_data.rd !== 5'd3) begin n_fail++; $display("FAIL pushpop_rd got %0d exp 3", wbrf_tdata.ex_data.rd); end
    tick();
    set_disp(1'b0, 2'b00, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (wbrf_tvalid !== 1'b1) begin n_fail++; $display("FAIL drain%0d_vld got %0b exp 1", i, wbrf_tvalid); end
      n_tests++; if (wbrf_tdata.ex_data.rd !== 5'(4 + i)) begin n_fail++; $display("FAIL drain%0d_rd got %0d exp %0d", i, wbrf_tdata.ex_data.rd, 4 + i); end
      tick();
    end
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL drained_vld got %0b exp 0", wbrf_tvalid); end
    n_tests++; if (fu_tready !== 2'b00) begin n_fail++; $display("FAIL drained_fu_rdy got %b exp 00", fu_tready); end
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_pcg_stall();
    set_disp(1'b1, 2'b10, 5'd8);
    tick();
    set_disp(1'b0, 2'b00, 5'd0);
    wbpcg_tready = 1'b0;
    set_fu(1, 1'b1, 32'h5, 1'b1, 32'h100);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL stall%0d_wbrf_vld got %0b exp 0", i, wbrf_tvalid); end
      n_tests++; if (fu_tready !== 2'b00) begin n_fail++; $display("FAIL stall%0d_fu_rdy got %b exp 00", i, fu_tready); end
      n_tests++; if (wbpcg_tvalid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_pcg_vld got %0b exp 1", i, wbpcg_tvalid); end
      tick();
    end
    wbpcg_tready = 1'b1;
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b1) begin n_fail++; $display("FAIL unstall_wbrf_vld got %0b exp 1", wbrf_tvalid); end
    n_tests++; if (fu_tready !== 2'b10) begin n_fail++; $display("FAIL unstall_fu_rdy got %b exp 10", fu_tready); end
    n_tests++; if (wbpcg_tdata !== 32'h100) begin n_fail++; $display("FAIL unstall_pcg_dat got %h exp 00000100", wbpcg_tdata); end
    tick();
    set_fu(1, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    n_tests++; if (wbpcg_tvalid !== 1'b0) begin n_fail++; $display("FAIL unstall_single_pcg got %0b exp 0", wbpcg_tvalid); end
  endtask

  task automatic test_redirect_push();
    set_disp(1'b1, 2'b10, 5'd10);
    tick();
    set_disp(1'b1, 2'b01, 5'd11);
    set_fu(1, 1'b1, 32'h0, 1'b1, 32'h200);
    #1;
    n_tests++; if (wbpcg_tvalid !== 1'b1) begin n_fail++; $display("FAIL rpush_pcg_vld got %0b exp 1", wbpcg_tvalid); end
    tick();
    set_disp(1'b0, 2'b00, 5'd0);
    set_fu(1, 1'b0, 32'd0, 1'b0, 32'd0);
    set_fu(0, 1'b1, 32'h77, 1'b0, 32'd0);
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL rpush_squash_vld got %0b exp 0", wbrf_tvalid); end
    n_tests++; if (fu_tready !== 2'b01) begin n_fail++; $display("FAIL rpush_squash_fu_rdy got %b exp 01", fu_tready); end
    tick();
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_disp(1'b1, 2'b01, 5'(20 + i));
      tick();
    end
    set_disp(1'b0, 2'b00, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_fu(0, 1'b1, 32'h99, 1'b0, 32'd0);
    #1;
    n_tests++; if (wbrf_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wbrf_vld got %0b exp 0", wbrf_tvalid); end
    n_tests++; if (wbpcg_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_pcg_vld got %0b exp 0", wbpcg_tvalid); end
    n_tests++; if (fu_tready !== 2'b00) begin n_fail++; $display("FAIL rstmid_fu_rdy got %b exp 00", fu_tready); end
    n_tests++; if (disp_tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_disp_rdy got %0b exp 1", disp_tready); end
`ifdef COMMIT_INSTRET_EN
    n_tests++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rstmid_instret got %0d exp 0", instret); end
`endif
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

`ifdef COMMIT_INSTRET_EN
  task automatic test_instret();
    for (int i = 0; i < 9; i++) begin
      set_disp(1'b1, 2'b01, 5'(i));
      tick();
      set_disp(1'b0, 2'b00, 5'd0);
      set_fu(0, 1'b1, 32'(i), 1'b0, 32'd0);
      tick();
      set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    #1;
    n_tests++; if (instret !== 64'd9) begin n_fail++; $display("FAIL instret_9 got %0d exp 9", instret); end
    set_disp(1'b1, 2'b10, 5'd12); tick();
    set_disp(1'b1, 2'b01, 5'd13); tick();
    set_disp(1'b1, 2'b01, 5'd14); tick();
    set_disp(1'b0, 2'b00, 5'd0);
    set_fu(1, 1'b1, 32'h0, 1'b1, 32'h40);
    tick();
    set_fu(1, 1'b0, 32'd0, 1'b0, 32'd0);
    set_fu(0, 1'b1, 32'h1, 1'b0, 32'd0);
    tick();
    tick();
    set_fu(0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    n_tests++; if (instret !== 64'd10) begin n_fail++; $display("FAIL instret_10 got %0d exp 10", instret); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_no_fu();
    test_redirect();
    test_full();
    test_pcg_stall();
    test_redirect_push();
    test_reset_mid();
`ifdef COMMIT_INSTRET_EN
    test_instret();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
